dcache_controller: RTL
======================

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have no parameters: 16 lines, direct-mapped, 256-bit lines, 32-bit words, write-back, write-allocate.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cpu_addr_i  input  32  CPU byte address; word-aligned, bits [1:0] ignored.
REQ-005 SHALL have port: cpu_data_i  input  32  CPU store data.
REQ-006 SHALL have port: cpu_MemRead_i  input  1  load request.
REQ-007 SHALL have port: cpu_MemWrite_i  input  1  store request.
REQ-008 SHALL have port: cpu_data_o  output  32  load data.
REQ-009 SHALL have port: cpu_stall_o  output  1  CPU must hold its request while high.
REQ-010 SHALL have port: mem_addr_o  output  32  line address to data memory, bits [4:0] = 0.
REQ-011 SHALL have port: mem_data_o  output  256  victim line for writeback.
REQ-012 SHALL have port: mem_enable_o  output  1  memory request.
REQ-013 SHALL have port: mem_write_o  output  1  1 = write, 0 = read.
REQ-014 SHALL have port: mem_data_i  input  256  line from data memory, valid the cycle after mem_ack_i.
REQ-015 SHALL have port: mem_ack_i  input  1  memory completion, one-cycle pulse.

Function
REQ-016 SHALL split address as offset [4:0], word select [4:2], index [8:5], tag [31:9] (23 bits).
REQ-017 SHALL store per line: valid, dirty, 23-bit tag, 256-bit data.
REQ-018 SHALL define request = cpu_MemRead_i | cpu_MemWrite_i; both high treated as write.
REQ-019 SHALL define hit = request & valid[index] & (tag[index] == addr tag), evaluated combinationally in IDLE only.
REQ-020 SHALL use states IDLE, WRITEBACK, ALLOCATE, REFILL.
REQ-021 SHALL drive cpu_stall_o = request & ~(state==IDLE & hit), combinationally.
REQ-022 SHALL, on read hit, drive cpu_data_o with the selected word in the same cycle; otherwise cpu_data_o = 0.
REQ-023 SHALL, on write hit, replace the selected word at the next edge and set dirty; other words unchanged.
REQ-024 SHALL, in IDLE on a miss, go to WRITEBACK if the victim is valid and dirty, else ALLOCATE.
REQ-025 SHALL, in WRITEBACK, drive mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line; on mem_ack_i go to ALLOCATE.
REQ-026 SHALL, in ALLOCATE, drive mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}; on mem_ack_i go to REFILL.
REQ-027 SHALL, in REFILL, drive mem_enable_o=0, write mem_data_i into the line with valid=1, dirty=0, new tag, then return to IDLE.
REQ-028 SHALL complete the original access in IDLE as a hit on the cycle after REFILL; a write miss thus sets dirty.
REQ-029 SHALL ignore mem_ack_i in IDLE and REFILL.
REQ-030 SHALL drive mem_enable_o, mem_write_o, mem_addr_o and mem_data_o to 0 in IDLE.
REQ-031 SHALL NOT change any line contents while cpu_stall_o is high, except in REFILL.

Reset
REQ-032 SHALL, while rst_i is low, force state=IDLE and clear all valid and dirty bits immediately (asynchronous). Tag and data contents are don't-care.
REQ-033 SHALL, on reset asserted mid-miss, drop mem_enable_o at once and abandon the transfer with no line update.
REQ-034 SHALL, with rst_i low and no request, hold every output at 0.

Verification
REQ-035 Reset, read 0x00 with a 10-cycle-ack memory -> one ALLOCATE (addr 0x00, write 0); stall high 12 cycles; then cpu_data_o = memory word 0.
REQ-036 Read 0x04 after REQ-035 -> stall 0 and word 1 returned in the same cycle.
REQ-037 Write 0xDEADBEEF to 0x08 (hit) -> no stall. Then read 0x208 -> WRITEBACK addr 0x00 with word 2 = 0xDEADBEEF, then ALLOCATE addr 0x200; stall high 22 cycles.
REQ-038 Write miss to clean index -> ALLOCATE only, no WRITEBACK. Line ends dirty with the stored word; other words come from memory.
REQ-039 rst_i low during ALLOCATE -> mem_enable_o=0 and stall=0 immediately. After release, read of the same address misses again.
REQ-040 No request for 20 cycles -> cpu_stall_o=0, mem_enable_o=0, state stays IDLE.

Source files
------------

// File: rtl/dcache_controller.sv
// dcache_controller
//   Direct-mapped, write-back, write-allocate data cache: 16 lines of 256 bits
//   (eight 32-bit words). Hits complete in the request cycle. A miss with a
//   dirty victim writes the victim line back first. The missing line is then
//   fetched, installed in REFILL, and the held request finishes as a hit.
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-low reset (clears valid/dirty, state)
//   cpu_addr_i      CPU byte address (bits [1:0] ignored)
//   cpu_data_i      CPU store data
//   cpu_MemRead_i   load request
//   cpu_MemWrite_i  store request (wins when both requests are high)
//   cpu_data_o      load data on a read hit, otherwise 0
//   cpu_stall_o     CPU holds its request while high
//   mem_addr_o      line address to memory, bits [4:0] = 0
//   mem_data_o      victim line during writeback
//   mem_enable_o    memory request
//   mem_write_o     1 = write, 0 = read
//   mem_data_i      line from memory, valid the cycle after mem_ack_i
//   mem_ack_i       one-cycle completion pulse from memory
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILL    = 2'd3
    } state_t;

    state_t         state_reg;
    logic [15:0]    valid_reg;
    logic [15:0]    dirty_reg;
    logic [22:0]    tag_mem  [16];
    logic [255:0]   data_mem [16];

    logic [3:0]     index;
    logic [2:0]     word_sel;
    logic [22:0]    cpu_tag;
    logic           request;
    logic           is_write;
    logic           line_valid;
    logic           line_dirty;
    logic [22:0]    victim_tag;
    logic [255:0]   victim_line;
    logic [255:0]   merged_line;
    logic [31:0]    line_words [8];
    logic           hit;
    logic           unused_addr_bits;

    assign index            = cpu_addr_i[8:5];
    assign word_sel         = cpu_addr_i[4:2];
    assign cpu_tag          = cpu_addr_i[31:9];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign request     = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_write    = cpu_MemWrite_i;
    assign line_valid  = valid_reg[index];
    assign line_dirty  = dirty_reg[index];
    assign victim_tag  = tag_mem[index];
    assign victim_line = data_mem[index];

    // Lookup is only meaningful in IDLE; in the other states the request is
    // being serviced and must keep stalling.
    assign hit = request & line_valid & (victim_tag == cpu_tag) & (state_reg == IDLE);

    // Split the addressed line into words and build the store-merged line.
    for (genvar gi = 0; gi < 8; gi++) begin : g_words
        assign line_words[gi] = victim_line[gi*32 +: 32];
        assign merged_line[gi*32 +: 32] =
            (word_sel == 3'(gi)) ? cpu_data_i : victim_line[gi*32 +: 32];
    end

    // Stall is masked during reset so an abandoned miss releases the CPU at once.
    assign cpu_stall_o = rst_i & request & ~hit;
    assign cpu_data_o  = (hit & ~is_write) ? line_words[word_sel] : 32'd0;

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'd0;
        mem_data_o   = 256'd0;
        case (state_reg)
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {victim_tag, index, 5'b0};
                mem_data_o   = victim_line;
            end
            ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {cpu_tag, index, 5'b0};
            end
            default: ;
        endcase
    end

    // Control state plus per-line valid/dirty flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            valid_reg <= 16'd0;
            dirty_reg <= 16'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (request && !hit) begin
                        state_reg <= (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
                    end else if (hit && is_write) begin
                        dirty_reg[index] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) state_reg <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (mem_ack_i) state_reg <= REFILL;
                end
                REFILL: begin
                    valid_reg[index] <= 1'b1;
                    dirty_reg[index] <= 1'b0;
                    state_reg        <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Tag and data arrays need no reset: valid_reg gates every use. Reset
    // forces IDLE with all lines invalid, so neither write can fire then.
    always_ff @(posedge clk_i) begin
        if (state_reg == REFILL) begin
            data_mem[index] <= mem_data_i;
            tag_mem[index]  <= cpu_tag;
        end else if (hit && is_write) begin
            data_mem[index] <= merged_line;
        end
    end

endmodule
